sd_resp_recv: RTL and testbench

Receives SD card command responses on the CMD line. It is the receive-side counterpart of sd_send. After a command has been sent, the controller arms this block. The block waits for the card's start bit, shifts in a 48-bit (R1/R3/R6/R7) or 136-bit (R2) response, checks framing and CRC7, and presents the decoded index, payload and error flags to the host FSM.

---
 rtl/sd_resp_recv_if.sv | 31 +++
 rtl/sd_resp_recv.sv | 135 +++++++++++++
 tb/tb_sd_resp_recv.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sd_resp_recv_if.sv
// Bus bundle between the host FSM and the SD response receiver.
// Handshake: the host pulses recv_en (only honoured while the receiver is idle);
// receiving stays high until the single-cycle resp_valid pulse. At that pulse
// resp_index, resp_content and the error flags are valid. They hold until the
// next arming. There is no back-pressure: the host must take the result on that cycle.
interface sd_resp_recv_if;
    logic         recv_en;
    logic         long_resp;
    logic         crc_check_en;
    logic         sd_cmd;
    logic         receiving;
    logic         resp_valid;
    logic [5:0]   resp_index;
    logic [127:0] resp_content;
    logic         crc_err;
    logic         tx_err;
    logic         end_err;
    logic         timeout;

    modport master (
        output recv_en, long_resp, crc_check_en, sd_cmd,
        input  receiving, resp_valid, resp_index, resp_content,
               crc_err, tx_err, end_err, timeout
    );

    modport slave (
        input  recv_en, long_resp, crc_check_en, sd_cmd,
        output receiving, resp_valid, resp_index, resp_content,
               crc_err, tx_err, end_err, timeout
    );
endinterface

// File: rtl/sd_resp_recv.sv
// SD CMD-line response receiver: waits for a start bit, shifts in a 48-bit or
// 136-bit response MSB first, checks transmission bit, CRC7 and end bit, and
// presents the decoded fields with a one-cycle resp_valid pulse.
module sd_resp_recv #(
    parameter int         TIMEOUT_CYCLES = 64,
    parameter logic [6:0] CRC_POLY       = 7'h09
) (
    input  logic            sd_clk,
    input  logic            reset,
    sd_resp_recv_if.slave   bus,
    output logic [1:0]      dbg_state
);

    typedef enum logic [1:0] {IDLE, WAIT_START, RECV, DONE} state_t;

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    state_t         state, state_nxt;
    logic [TW-1:0]  tmo_cnt;
    logic [7:0]     bit_cnt;     // index of the bit sampled on the previous edge
    logic [7:0]     bit_idx;     // index of the bit being sampled on this edge
    logic           long_l;
    logic           crc_en_l;
    logic [6:0]     crc;
    logic [6:0]     crc_next;
    logic           crc_fb;
    logic [126:0]   shreg;       // shreg[i] holds received bit i+1 once bit 0 arrives
    logic [5:0]     index_r;
    logic [127:0]   content_r;
    logic           crc_err_r, tx_err_r, end_err_r, timeout_r;

    assign bit_idx  = bit_cnt - 8'd1;
    assign crc_fb   = crc[6] ^ bus.sd_cmd;
    assign crc_next = {crc[5:0], 1'b0} ^ (crc_fb ? CRC_POLY : 7'h00);

    assign bus.receiving    = (state == WAIT_START) || (state == RECV);
    assign bus.resp_valid   = (state == DONE);
    assign bus.resp_index   = index_r;
    assign bus.resp_content = content_r;
    assign bus.crc_err      = crc_err_r;
    assign bus.tx_err       = tx_err_r;
    assign bus.end_err      = end_err_r;
    assign bus.timeout      = timeout_r;
    assign dbg_state        = state;

    // State register.
    always_ff @(posedge sd_clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state: arm, wait for start bit or timeout, count bits, one DONE cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:       if (bus.recv_en) state_nxt = WAIT_START;
            WAIT_START: begin
                if (!bus.sd_cmd)              state_nxt = RECV;
                else if (tmo_cnt == TW'(1))   state_nxt = DONE;
            end
            RECV:       if (bit_cnt == 8'd1) state_nxt = DONE;
            DONE:       state_nxt = IDLE;
            default:    state_nxt = IDLE;
        endcase
    end

    // Datapath: arming clears results, reception shifts bits, CRC and flags,
    // and the decoded fields are loaded only on the end-bit edge.
    always_ff @(posedge sd_clk) begin
        if (reset) begin
            tmo_cnt   <= '0;
            bit_cnt   <= '0;
            long_l    <= 1'b0;
            crc_en_l  <= 1'b0;
            crc       <= '0;
            shreg     <= '0;
            index_r   <= '0;
            content_r <= '0;
            crc_err_r <= 1'b0;
            tx_err_r  <= 1'b0;
            end_err_r <= 1'b0;
            timeout_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.recv_en) begin
                        tmo_cnt   <= TW'(TIMEOUT_CYCLES);
                        bit_cnt   <= '0;
                        long_l    <= bus.long_resp;
                        crc_en_l  <= bus.crc_check_en;
                        crc       <= '0;
                        shreg     <= '0;
                        index_r   <= '0;
                        content_r <= '0;
                        crc_err_r <= 1'b0;
                        tx_err_r  <= 1'b0;
                        end_err_r <= 1'b0;
                        timeout_r <= 1'b0;
                    end
                end
                WAIT_START: begin
                    // The start bit is a 0 entering an all-zero CRC, so the
                    // CRC stays 0 and needs no update here.
                    if (!bus.sd_cmd) begin
                        bit_cnt <= long_l ? 8'd135 : 8'd47;
                    end else begin
                        tmo_cnt <= tmo_cnt - TW'(1);
                        if (tmo_cnt == TW'(1)) timeout_r <= 1'b1;
                    end
                end
                RECV: begin
                    bit_cnt <= bit_idx;
                    if (bit_idx != 8'd0) shreg <= {shreg[125:0], bus.sd_cmd};
                    if ((bit_idx == (long_l ? 8'd134 : 8'd46)) && bus.sd_cmd)
                        tx_err_r <= 1'b1;
                    if ((bit_idx >= 8'd8) && (!long_l || (bit_idx <= 8'd127)))
                        crc <= crc_next;
                    if (bit_idx == 8'd0) begin
                        end_err_r <= !bus.sd_cmd;
                        if (crc_en_l && (crc != shreg[6:0])) crc_err_r <= 1'b1;
                        if (long_l) begin
                            index_r   <= 6'h3F;
                            content_r <= {shreg[126:0], 1'b0};
                        end else begin
                            index_r   <= shreg[44:39];
                            content_r <= {96'b0, shreg[38:7]};
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sd_resp_recv.sv
// Self-checking bench for sd_resp_recv: a driver issues framed responses and
// pushes the expected result, a monitor compares whenever resp_valid is seen.
module tb_sd_resp_recv;

    localparam int TMO = 64;

    logic       sd_clk = 1'b0;
    logic       reset;
    logic [1:0] dbg_state;
    int         cyc = 0;
    int         checks = 0;
    int         failures = 0;
    int         run = 0;

    // expected item: [137]=timeout [136]=end_err [135]=tx_err [134]=crc_err
    //                [133:128]=resp_index [127:0]=resp_content
    logic [137:0] exp_q[$];
    int           exp_cyc_q[$];
    int           exp_run_q[$];

    sd_resp_recv_if bus();

    sd_resp_recv #(.TIMEOUT_CYCLES(TMO)) dut (
        .sd_clk    (sd_clk),
        .reset     (reset),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // clock and cycle counter
    always #5 sd_clk = ~sd_clk;
    always @(posedge sd_clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // CRC7 as polynomial remainder of msg(x)*x^7 mod (x^7+x^3+1)
    function automatic logic [6:0] crc7_ref(input logic [135:0] msg, input int len);
        logic [142:0] r;
        r = {msg, 7'b0};
        for (int i = len + 6; i >= 7; i--)
            if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
        return r[6:0];
    endfunction

    // reference: decode a frame (bit n-1 first) straight from the field layout
    function automatic logic [137:0] model(input logic [135:0] f, input logic lng, input logic ce);
        logic [5:0]   idx;
        logic [127:0] c;
        logic         tx, ee, cerr;
        if (!lng) begin
            idx  = f[45:40];
            c    = {96'b0, f[39:8]};
            tx   = f[46];
            cerr = ce && (crc7_ref(136'(f[47:8]), 40) != f[7:1]);
        end else begin
            idx  = 6'h3F;
            c    = {f[127:1], 1'b0};
            tx   = f[134];
            cerr = ce && (crc7_ref(136'(f[127:8]), 120) != f[7:1]);
        end
        ee = !f[0];
        return {1'b0, ee, tx, cerr, idx, c};
    endfunction

    function automatic logic [135:0] make_short(input logic tx, input logic [5:0] idx,
                                                input logic [31:0] arg, input logic [6:0] flip,
                                                input logic endb);
        logic [39:0] hdr;
        logic [6:0]  c;
        hdr = {1'b0, tx, idx, arg};
        c   = crc7_ref(136'(hdr), 40) ^ flip;
        return 136'({hdr, c, endb});
    endfunction

    function automatic logic [135:0] make_long(input logic tx, input logic [119:0] cid,
                                               input logic [6:0] flip, input logic endb);
        logic [6:0] c;
        c = crc7_ref(136'(cid), 120) ^ flip;
        return {1'b0, tx, 6'h3F, cid, c, endb};
    endfunction

    // driver: arm pulse; mode inputs are scrambled afterwards to prove latching
    task automatic arm(input logic lng, input logic ce);
        bus.recv_en      = 1'b1;
        bus.long_resp    = lng;
        bus.crc_check_en = ce;
        bus.sd_cmd       = 1'b1;
        @(posedge sd_clk); #2;
        bus.recv_en      = 1'b0;
        bus.long_resp    = ~lng;
        bus.crc_check_en = ~ce;
    endtask

    task automatic send_frame(input logic [135:0] f, input logic lng, input logic ce,
                              input int idle, input int pulse_at);
        int n;
        n = lng ? 136 : 48;
        exp_q.push_back(model(f, lng, ce));
        exp_cyc_q.push_back(cyc + 1 + idle + n);
        exp_run_q.push_back(idle + n);
        arm(lng, ce);
        repeat (idle) begin
            bus.sd_cmd = 1'b1;
            @(posedge sd_clk); #2;
        end
        for (int i = n - 1; i >= 0; i--) begin
            bus.sd_cmd  = f[i];
            bus.recv_en = (i == pulse_at);
            @(posedge sd_clk); #2;
        end
        bus.recv_en = 1'b0;
        bus.sd_cmd  = 1'b1;
        @(posedge sd_clk); #2;   // DONE cycle; next arm lands in the following IDLE cycle
    endtask

    task automatic send_timeout();
        exp_q.push_back({1'b1, 3'b000, 6'h00, 128'h0});
        exp_cyc_q.push_back(cyc + 1 + TMO);
        exp_run_q.push_back(TMO);
        arm(1'b0, 1'b1);
        repeat (TMO + 1) begin
            bus.sd_cmd = 1'b1;
            @(posedge sd_clk); #2;
        end
    endtask

    // monitor / scoreboard
    initial begin
        logic [137:0] e;
        int           ec, er;
        forever begin
            @(negedge sd_clk);
            if (exp_cyc_q.size() > 0 && cyc > exp_cyc_q[0]) begin
                checks++;
                failures++;
                $display("FAIL resp_valid_missing actual=none required=cycle_%0d", exp_cyc_q[0]);
                void'(exp_q.pop_front());
                void'(exp_cyc_q.pop_front());
                void'(exp_run_q.pop_front());
            end
            if (bus.resp_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL resp_valid_unexpected actual=1 required=0 cycle=%0d", cyc);
                end else begin
                    e  = exp_q.pop_front();
                    ec = exp_cyc_q.pop_front();
                    er = exp_run_q.pop_front();
                    check("resp_cycle",   cyc,              ec);
                    check("resp_index",   bus.resp_index,   e[133:128]);
                    check("resp_content", bus.resp_content, e[127:0]);
                    check("crc_err",      bus.crc_err,      e[134]);
                    check("tx_err",       bus.tx_err,       e[135]);
                    check("end_err",      bus.end_err,      e[136]);
                    check("timeout",      bus.timeout,      e[137]);
                    check("receiving_in_done", bus.receiving, 1'b0);
                    check("receiving_run", run, er);
                end
            end
            if (bus.receiving === 1'b1) run++;
            else                        run = 0;
        end
    end

    // main stimulus
    initial begin
        logic [135:0] f;
        logic [127:0] r;
        logic [119:0] cid;
        logic         ce;

        reset            = 1'b1;
        bus.recv_en      = 1'b0;
        bus.long_resp    = 1'b0;
        bus.crc_check_en = 1'b0;
        bus.sd_cmd       = 1'b1;
        repeat (3) @(posedge sd_clk);
        #2 reset = 1'b0;
        @(negedge sd_clk);
        check("rst_receiving",  bus.receiving,    1'b0);
        check("rst_resp_valid", bus.resp_valid,   1'b0);
        check("rst_index",      bus.resp_index,   6'h00);
        check("rst_content",    bus.resp_content, 128'h0);
        check("rst_flags", {bus.crc_err, bus.tx_err, bus.end_err, bus.timeout}, 4'b0000);
        @(posedge sd_clk); #2;

        // R7 reply
        send_frame(136'(48'h08_000001AA_13), 1'b0, 1'b1, 3, -1);
        check("r7_index",   bus.resp_index,         6'h08);
        check("r7_content", bus.resp_content[31:0], 32'h000001AA);
        check("r7_flags", {bus.crc_err, bus.tx_err, bus.end_err, bus.timeout}, 4'b0000);

        // corrupted payload, sent back-to-back
        send_frame(136'(48'h08_000001AB_13), 1'b0, 1'b1, 0, -1);
        check("bad_payload_crc", bus.crc_err, 1'b1);
        check("bad_payload_tx_end", {bus.tx_err, bus.end_err}, 2'b00);
        check("bad_payload_content", bus.resp_content[31:0], 32'h000001AB);

        // command token echoed as a response
        send_frame(136'(48'h51_00000000_55), 1'b0, 1'b1, 2, -1);
        check("echo_tx", bus.tx_err, 1'b1);
        check("echo_crc", bus.crc_err, 1'b0);
        check("echo_index", bus.resp_index, 6'h11);

        // R3 with and without CRC checking, then a bad end bit
        send_frame(136'(48'h3F_80FF8000_FF), 1'b0, 1'b0, 1, -1);
        check("r3_index", bus.resp_index, 6'h3F);
        check("r3_content", bus.resp_content[31:0], 32'h80FF8000);
        check("r3_flags", {bus.crc_err, bus.tx_err, bus.end_err}, 3'b000);
        send_frame(136'(48'h3F_80FF8000_FF), 1'b0, 1'b1, 1, -1);
        check("r3_crc_on", bus.crc_err, 1'b1);
        send_frame(136'(48'h08_000001AA_12), 1'b0, 1'b1, 1, -1);
        check("end_bit_zero", bus.end_err, 1'b1);
        check("end_bit_zero_crc", bus.crc_err, 1'b0);

        // timeout, flag hold, start bit on the last allowed cycle, re-arm ignored
        send_timeout();
        repeat (3) @(posedge sd_clk);
        #2;
        check("timeout_hold", bus.timeout, 1'b1);
        send_frame(136'(48'h08_000001AA_13), 1'b0, 1'b1, TMO - 1, -1);
        send_frame(136'(48'h08_000001AA_13), 1'b0, 1'b1, 2, 20);

        // R2 with the reference CID
        cid = 120'h03_5344_5344303847_80_12345678_00C5;
        f   = make_long(1'b0, cid, 7'h00, 1'b1);
        send_frame(f, 1'b1, 1'b1, 4, -1);
        check("r2_content", bus.resp_content, {cid, crc7_ref(136'(cid), 120), 1'b0});
        check("r2_crc", bus.crc_err, 1'b0);

        // random short responses
        for (int k = 0; k < 30; k++) begin
            ce = 1'($urandom_range(0, 3) != 0);
            f  = make_short(1'($urandom_range(0, 7) == 0), 6'($urandom), $urandom,
                            ($urandom_range(0, 5) == 0) ? 7'(1 << $urandom_range(0, 6)) : 7'h00,
                            1'($urandom_range(0, 7) != 0));
            send_frame(f, 1'b0, ce, $urandom_range(0, 10), -1);
        end

        // random long responses
        for (int k = 0; k < 6; k++) begin
            r  = {$urandom, $urandom, $urandom, $urandom};
            ce = 1'($urandom_range(0, 3) != 0);
            f  = make_long(1'($urandom_range(0, 5) == 0), r[119:0],
                           ($urandom_range(0, 3) == 0) ? 7'(1 << $urandom_range(0, 6)) : 7'h00,
                           1'($urandom_range(0, 7) != 0));
            send_frame(f, 1'b1, ce, $urandom_range(0, 6), -1);
        end

        // reset while bit 70 of a second R2 is on the line: no resp_valid
        f = make_long(1'b0, cid, 7'h00, 1'b1);
        arm(1'b1, 1'b1);
        for (int i = 135; i > 70; i--) begin
            bus.sd_cmd = f[i];
            @(posedge sd_clk); #2;
        end
        bus.sd_cmd = f[70];
        reset      = 1'b1;
        @(posedge sd_clk); #2;
        reset      = 1'b0;
        bus.sd_cmd = 1'b1;
        @(negedge sd_clk);
        check("abort_receiving", bus.receiving, 1'b0);
        check("abort_content",   bus.resp_content, 128'h0);
        check("abort_index",     bus.resp_index, 6'h00);
        check("abort_flags", {bus.resp_valid, bus.crc_err, bus.tx_err, bus.end_err, bus.timeout}, 5'b00000);
        check("abort_state",     dbg_state, 2'd0);
        repeat (80) @(posedge sd_clk);
        #2;

        // recovery after the abort
        send_frame(136'(48'h08_000001AA_13), 1'b0, 1'b1, 1, -1);

        repeat (5) @(posedge sd_clk);
        #2;
        check("pending_expected", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
